// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding.
package div_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'b000,
    S_ITER = 3'b001,
    S_DONE = 3'b010
  } state_e;

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract D, keep or restore.
module div_sub_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;

  // The shifted remainder needs WIDTH+1 bits: R < D can exceed 2^(WIDTH-1).
  assign r_sh = {r_i, q_i[WIDTH-1]};
  assign diff = r_sh - {1'b0, d_i};

  // Either branch fits in WIDTH bits: a kept difference is < D, a restored R_sh is < D.
  assign r_o = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_o = {q_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/param_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module param_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_dividend,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic               o_busy,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_quotient,
  output logic [WIDTH-1:0]   o_remainder,
  output logic               o_div_by_zero,
  output logic [STATE_W-1:0] o_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   r_q, q_q, d_q;
  logic [WIDTH-1:0]   r_d, q_d;
  logic [WIDTH-1:0]   quo_q, rem_q;
  logic               busy_q, done_q, dbz_q;

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_d),
    .q_o (q_d)
  );

  // NOTE: sequential state uses <= only, so every register sees pre-edge values and
  // later assignments in the same block simply override earlier defaults.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            d_q    <= i_divisor;
            dbz_q  <= 1'b0;
            busy_q <= 1'b1;
            if (i_divisor == '0) begin
              quo_q   <= '1;
              rem_q   <= i_dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              r_q     <= '0;
              q_q     <= i_dividend;
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= S_ITER;
            end
          end
        end
        S_ITER: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            quo_q   <= q_d;
            rem_q   <= r_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_quotient    = quo_q;
  assign o_remainder   = rem_q;
  assign o_div_by_zero = dbz_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_param_restoring_divider.sv
// Directed self-checking bench for param_restoring_divider at WIDTH=8.
module tb_param_restoring_divider;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend, divisor;
  logic             busy, done, dbz;
  logic [WIDTH-1:0] quotient, remainder;
  logic [2:0]       state;

  int total = 0;
  int bad   = 0;

  param_restoring_divider #(.WIDTH(WIDTH)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dbz),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division and follow it through DONE and the following IDLE cycle.
  task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                        input int elat);
    int n;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        start = 1'b0; dividend = ~a; divisor = ~b;
      end
    end while (!done && n < 40);
    check({tag, "_done"}, done, 1);
    check({tag, "_lat"}, n, elat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, dbz, edbz);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_st_done"}, state, 3'b010);
    tick();
    check({tag, "_pulse"}, done, 0);
    check({tag, "_st_idle"}, state, 3'b000);
    check({tag, "_held_q"}, quotient, eq);
    check({tag, "_held_r"}, remainder, er);
  endtask

  initial begin
    int ndone;
    logic [7:0] seen_q, seen_r;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) tick();
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", dbz, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: each call starts in the IDLE cycle right after the previous DONE.
    do_div("d100_7",   8'd100, 8'd7,   8'd14,  8'd2,  1'b0, WIDTH + 1);
    do_div("d37_0",    8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 1);
    do_div("d200_200", 8'd200, 8'd200, 8'd1,   8'd0,  1'b0, WIDTH + 1);
    do_div("d255_1",   8'd255, 8'd1,   8'd255, 8'd0,  1'b0, WIDTH + 1);
    do_div("d5_9",     8'd5,   8'd9,   8'd0,   8'd5,  1'b0, WIDTH + 1);
    do_div("d255_200", 8'd255, 8'd200, 8'd1,   8'd55, 1'b0, WIDTH + 1);
    do_div("d0_5",     8'd0,   8'd5,   8'd0,   8'd0,  1'b0, WIDTH + 1);
    do_div("d250_17",  8'd250, 8'd17,  8'd14,  8'd12, 1'b0, WIDTH + 1);

    // A start pulse during ITER carrying other operands must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("ign_state_iter", state, 3'b001);
    check("ign_busy", busy, 1);
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    tick();
    start = 1'b0;
    ndone = 0; seen_q = '0; seen_r = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) begin
        ndone++; seen_q = quotient; seen_r = remainder;
      end
    end
    check("ign_ndone", ndone, 1);
    check("ign_q", seen_q, 14);
    check("ign_r", seen_r, 2);
    check("ign_final_idle", state, 0);

    // Reset in the middle of an iteration aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mid_rst_state", state, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_q", quotient, 0);
    check("mid_rst_r", remainder, 0);
    check("mid_rst_dbz", dbz, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    do_div("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, WIDTH + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
